// File: rtl/shift_add_pkg.sv
// rtl/shift_add_pkg.sv - shared state encoding and defaults for the shift-and-add multiplier control
package shift_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_add_adder.sv
// rtl/shift_add_adder.sv - combinational ripple adder with carry-out, {cout,sum} = a + b
module shift_add_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[WIDTH];
  end

endmodule

// File: rtl/shift_add_ctrl.sv
// rtl/shift_add_ctrl.sv - control and accumulator stage of the shift-and-add multiplier
// Optional DONE_HOLD_EN: done becomes a level held through IDLE until the next accepted start.
module shift_add_ctrl
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic             q0,
  output logic             q_load,
  output logic             q_en,
  output logic             q_sin,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             e_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic             last_shift;

  assign last_shift = (cnt_q == CNT_W'(1));

  shift_add_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a_q),
    .b    (b_q),
    .sum  (sum),
    .cout (sum_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs depend only on state_q: the shift register gates its clock with q_en.
  always_comb begin
    state_d = state_q;
    q_load  = 1'b0;
    q_en    = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        q_load  = 1'b1;
        q_en    = 1'b1;
        busy    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        q_en    = 1'b1;
        busy    = 1'b1;
        state_d = last_shift ? DONE : ADD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      e_q   <= 1'b0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          b_q   <= multiplicand;
          a_q   <= '0;
          e_q   <= 1'b0;
          cnt_q <= CNT_W'(WIDTH);
        end
        ADD: if (q0) {e_q, a_q} <= {sum_cout, sum};
        SHIFT: begin
          a_q   <= {e_q, a_q[WIDTH-1:1]};
          e_q   <= 1'b0;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DONE_HOLD_EN
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                done_q <= 1'b0;
    else if (state_q == IDLE && start)         done_q <= 1'b0;
    else if (state_q == SHIFT && last_shift)   done_q <= 1'b1;
  end

  assign done = done_q;
`else
  assign done = (state_q == DONE);
`endif

  assign acc   = a_q;
  assign q_sin = a_q[0];

endmodule

// File: tb/tb_shift_add_ctrl.sv
// tb/tb_shift_add_ctrl.sv - self-checking bench: control stage paired with a multiplier shift register
module tb_shift_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] multiplicand = 8'h00;
  logic       q0;
  logic       q_load, q_en, q_sin, busy, done;
  logic [7:0] acc;

  logic [7:0] mplier = 8'h00;
  logic [7:0] q_reg = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_add_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .q0           (q0),
    .q_load       (q_load),
    .q_en         (q_en),
    .q_sin        (q_sin),
    .acc          (acc),
    .busy         (busy),
    .done         (done)
  );

  // Multiplier right-shift register the control block drives.
  always @(posedge clk) begin
    if (q_en) q_reg <= q_load ? mplier : {q_sin, q_reg[7:1]};
  end
  assign q0 = q_reg[0];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: k = cycles since the accepting edge (0 = idle), product = a*b.
  int          k = 0;
  logic [7:0]  cap_b = 8'h00, cap_m = 8'h00;
  logic [15:0] prod = 16'h0000;
  logic        hold = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= 0;
      prod <= 16'h0000;
      hold <= 1'b0;
    end else if (k == 0) begin
      if (start) begin
        k     <= 1;
        cap_b <= multiplicand;
        cap_m <= mplier;
        hold  <= 1'b0;
      end
    end else if (k == 18) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if (k == 17) begin
        prod <= 16'(cap_b) * 16'(cap_m);
        hold <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_done;
`ifdef DONE_HOLD_EN
      exp_done = (k == 18) || (k == 0 && hold);
`else
      exp_done = (k == 18);
`endif
      check("busy", 16'(busy), 16'(k >= 1 && k <= 17));
      check("done", 16'(done), 16'(exp_done));
      check("q_load", 16'(q_load), 16'(k == 1));
      check("q_en", 16'(q_en), 16'(k == 1 || (k >= 3 && k <= 17 && (k % 2) == 1)));
      if (k == 0 || k == 18) check("acc_hi", 16'(acc), 16'(prod[15:8]));
      if (k == 1) check("acc_clear", 16'(acc), 16'h0000);
      if (k == 18) check("q_lo", 16'(q_reg), 16'(prod[7:0]));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 16'h0000, 16'h0001);
    start = 1'b0;
    tick();
  endtask

  task automatic run_op(input string name, input logic [7:0] b, input logic [7:0] m,
                        input logic [7:0] hi, input logic [7:0] lo, input logic zero_mon);
    int lat;
    lat = 0;
    multiplicand = b;
    mplier       = m;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (zero_mon) check({name, "_acc_zero"}, 16'(acc), 16'h0000);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 16'(lat), 16'd18);
    check({name, "_acc"}, 16'(acc), 16'(hi));
    check({name, "_q"}, 16'(q_reg), 16'(lo));
    tick();
  endtask

  initial begin
    int busy_cnt;
    #7;
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    check("rst_q_en", 16'(q_en), 16'h0000);
    check("rst_q_load", 16'(q_load), 16'h0000);
    check("rst_acc", 16'(acc), 16'h0000);
    #1 rst_n = 1'b1;
    tick();

    run_op("t1_13x11", 8'd13, 8'd11, 8'h00, 8'h8F, 1'b0);
    run_op("t2_255x255", 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0);
    run_op("t3_0x200", 8'd0, 8'd200, 8'h00, 8'h00, 1'b1);

    // Start held high: one multiply, then a second one starting right after DONE.
    multiplicand = 8'd3;
    mplier       = 8'd5;
    start        = 1'b1;
    tick();
    busy_cnt = 0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (c == 18) check("t4_done_c18", 16'(done), 16'h0001);
    end
    check("t4_busy_cycles", 16'(busy_cnt), 16'd17);
    @(negedge clk);
    check("t4_restart", 16'(busy), 16'h0001);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t4_second");

    // Asynchronous reset in cycle 7 of an operation.
    multiplicand = 8'd100;
    mplier       = 8'd77;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #1 rst_n = 1'b0;
    #1;
    check("t5_busy", 16'(busy), 16'h0000);
    check("t5_done", 16'(done), 16'h0000);
    check("t5_q_en", 16'(q_en), 16'h0000);
    check("t5_q_load", 16'(q_load), 16'h0000);
    check("t5_acc", 16'(acc), 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    run_op("t5_6x7", 8'd6, 8'd7, 8'h00, 8'h2A, 1'b0);

`ifdef DONE_HOLD_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t6_done_hold", 16'(done), 16'h0001);
    end
    @(posedge clk);
    #1;
    multiplicand = 8'd9;
    mplier       = 8'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check("t6_done_clear", 16'(done), 16'h0000);
    wait_done("t6_op");
`endif

    // Random operations with stray start pulses and multiplicand noise while busy.
    for (int n = 0; n < 40; n++) begin
      int seen;
      multiplicand = 8'($urandom);
      mplier       = 8'($urandom);
      start        = 1'b1;
      tick();
      start = 1'b0;
      seen  = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          break;
        end
        @(posedge clk);
        #1;
        start        = 1'($urandom_range(0, 1));
        multiplicand = 8'($urandom);
      end
      start = 1'b0;
      if (!seen) check("rand_timeout", 16'h0000, 16'h0001);
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
